seq_match_sched: RTL and testbench

- Shares one serial pattern-match engine across NCH independent 1-bit serial channels.
- A round-robin arbiter accepts at most one bit per cycle and restores that channel's saved context (history, fill count). It updates the context and reports a registered match pulse tagged with the channel index.
- The target pattern and the overlap mode are configurable at run time through a single-cycle config write.
- Sits between the serial front-end channels and the event/interrupt logic.

---
 rtl/seq_match_sched.sv | 135 +++++++++++++
 tb/tb_seq_match_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_match_sched.sv
// Serial pattern matcher shared round-robin across NCH 1-bit channels.
// Each channel keeps its own history/fill context; the engine processes one
// granted bit per cycle and emits a registered match pulse tagged with the
// channel index. Optional per-channel match counters: define MATCH_CNT_EN.
module seq_match_sched #(
  parameter int unsigned     NCH         = 4,
  parameter int unsigned     PLEN        = 4,
  parameter logic [PLEN-1:0] DEFAULT_PAT = PLEN'(4'b1011),
  parameter logic            DEFAULT_OVL = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [PLEN-1:0]          cfg_pattern,
  input  logic                     cfg_overlap,
  input  logic [NCH-1:0]           ch_valid,
  input  logic [NCH-1:0]           ch_data,
  output logic [NCH-1:0]           ch_ready,
  output logic                     match_valid,
  output logic [$clog2(NCH)-1:0]   match_ch
`ifdef MATCH_CNT_EN
  ,
  input  logic [$clog2(NCH)-1:0]   cnt_sel,
  output logic [7:0]               cnt_rdata
`endif
);

  localparam int unsigned CW = $clog2(NCH);
  localparam int unsigned FW = $clog2(PLEN + 1);

  logic [PLEN-1:0] pattern;
  logic            overlap;
  logic [CW-1:0]   ptr;
  logic [PLEN-1:0] hist [NCH];
  logic [FW-1:0]   fill [NCH];

  logic [CW-1:0]   cand;
  logic [CW-1:0]   gnt_idx;
  logic            gnt_found;
  logic            xfer;
  logic [CW-1:0]   ptr_next;
  logic [PLEN-1:0] h_new;
  logic [FW-1:0]   f_new;
  logic [FW-1:0]   f_upd;
  logic            hit;

  // Round-robin search starting at ptr, wrapping past NCH-1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      cand = CW'((32'(ptr) + k) % NCH);
      if (!gnt_found && ch_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Grant is suppressed during a config write and while reset is held.
  always_comb begin
    xfer     = gnt_found && !cfg_we;
    ch_ready = (xfer && rst) ? (NCH'(1) << gnt_idx) : '0;
    ptr_next = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
  end

  // Context update for the granted channel; non-overlap restarts the fill.
  always_comb begin
    h_new = {hist[gnt_idx][PLEN-2:0], ch_data[gnt_idx]};
    f_new = (fill[gnt_idx] == FW'(PLEN)) ? FW'(PLEN) : fill[gnt_idx] + FW'(1);
    hit   = xfer && (f_new == FW'(PLEN)) && (h_new == pattern);
    if (hit) begin
      f_upd = overlap ? FW'(PLEN) : '0;
    end else begin
      f_upd = f_new;
    end
  end

  // Config, arbitration pointer, channel contexts and match output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern     <= DEFAULT_PAT;
      overlap     <= DEFAULT_OVL;
      ptr         <= '0;
      match_valid <= 1'b0;
      match_ch    <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        hist[i] <= '0;
        fill[i] <= '0;
      end
    end else if (cfg_we) begin
      pattern     <= cfg_pattern;
      overlap     <= cfg_overlap;
      match_valid <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        hist[i] <= '0;
        fill[i] <= '0;
      end
    end else begin
      match_valid <= hit;
      if (xfer) begin
        hist[gnt_idx] <= h_new;
        fill[gnt_idx] <= f_upd;
        match_ch      <= gnt_idx;
        ptr           <= ptr_next;
      end
    end
  end

`ifdef MATCH_CNT_EN
  logic [7:0] cnt [NCH];

  // Saturating per-channel hit counters, cleared by reset and config writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else if (hit && (cnt[gnt_idx] != 8'hFF)) begin
      cnt[gnt_idx] <= cnt[gnt_idx] + 8'd1;
    end
  end

  // Combinational counter readback.
  always_comb begin
    cnt_rdata = cnt[cnt_sel];
  end
`endif

endmodule

// File: tb/tb_seq_match_sched.sv
// Directed self-checking bench for seq_match_sched (NCH=4, PLEN=4).
// Counter checks are compiled in when MATCH_CNT_EN is defined.
module tb_seq_match_sched;

  localparam int NCH = 4;
  localparam int CW  = 2;

  logic            clk;
  logic            rst;
  logic            cfg_we;
  logic [3:0]      cfg_pattern;
  logic            cfg_overlap;
  logic [NCH-1:0]  ch_valid;
  logic [NCH-1:0]  ch_data;
  logic [NCH-1:0]  ch_ready;
  logic            match_valid;
  logic [CW-1:0]   match_ch;
`ifdef MATCH_CNT_EN
  logic [CW-1:0]   cnt_sel;
  logic [7:0]      cnt_rdata;
`endif

  int n_checks;
  int n_fail;

  seq_match_sched #(.NCH(4), .PLEN(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .ch_valid    (ch_valid),
    .ch_data     (ch_data),
    .ch_ready    (ch_ready),
    .match_valid (match_valid),
    .match_ch    (match_ch)
`ifdef MATCH_CNT_EN
    ,
    .cnt_sel     (cnt_sel),
    .cnt_rdata   (cnt_rdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one bit on one channel for one cycle; returns grant and match result.
  task automatic send_bit(input int ch, input logic b, output logic rdy,
                          output logic mv, output logic [CW-1:0] mc);
    ch_valid = NCH'(1) << ch;
    ch_data = '0;
    ch_data[ch] = b;
    #1;
    rdy = ch_ready[ch];
    @(posedge clk); #1;
    mv = match_valid;
    mc = match_ch;
    ch_valid = '0;
    ch_data = '0;
  endtask

  // One-cycle config write with all channels requesting.
  task automatic do_cfg(input logic [3:0] pat, input logic ovl,
                        output logic [NCH-1:0] rdy, output logic mv);
    cfg_we = 1'b1;
    cfg_pattern = pat;
    cfg_overlap = ovl;
    ch_valid = '1;
    #1;
    rdy = ch_ready;
    @(posedge clk); #1;
    mv = match_valid;
    cfg_we = 1'b0;
    ch_valid = '0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ch_valid = '1;
    #2;
    n_checks++;
    if (ch_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0000", ch_ready);
    end
    n_checks++;
    if (match_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mv: got %b want 0", match_valid);
    end
    n_checks++;
    if (match_ch !== 2'd0) begin
      n_fail++; $display("FAIL reset_mc: got %0d want 0", match_ch);
    end
    ch_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_overlap();
    logic [6:0] seq;
    logic [6:0] exp;
    logic rdy, mv;
    logic [CW-1:0] mc;
    seq = 7'b1011011;
    exp = 7'b0001001;
    for (int i = 0; i < 7; i++) begin
      send_bit(0, seq[6-i], rdy, mv, mc);
      n_checks++;
      if (rdy !== 1'b1) begin
        n_fail++; $display("FAIL ovl_ready bit %0d: got %b want 1", i, rdy);
      end
      n_checks++;
      if (mv !== exp[6-i]) begin
        n_fail++; $display("FAIL ovl_mv bit %0d: got %b want %b", i, mv, exp[6-i]);
      end
      if (exp[6-i]) begin
        n_checks++;
        if (mc !== 2'd0) begin
          n_fail++; $display("FAIL ovl_mc bit %0d: got %0d want 0", i, mc);
        end
      end
    end
  endtask

  task automatic test_nonoverlap();
    logic [9:0] seq;
    logic [9:0] exp;
    logic [NCH-1:0] crdy;
    logic rdy, mv;
    logic [CW-1:0] mc;
    do_cfg(4'b1011, 1'b0, crdy, mv);
    n_checks++;
    if (crdy !== 4'b0000) begin
      n_fail++; $display("FAIL cfg_ready: got %b want 0000", crdy);
    end
    n_checks++;
    if (mv !== 1'b0) begin
      n_fail++; $display("FAIL cfg_mv: got %b want 0", mv);
    end
    seq = 10'b1011011011;
    exp = 10'b0001000001;
    for (int i = 0; i < 10; i++) begin
      send_bit(0, seq[9-i], rdy, mv, mc);
      n_checks++;
      if (mv !== exp[9-i]) begin
        n_fail++; $display("FAIL novl_mv bit %0d: got %b want %b", i, mv, exp[9-i]);
      end
    end
    do_cfg(4'b1011, 1'b1, crdy, mv);
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq;
    logic [NCH-1:0] rdy;
    logic [NCH-1:0] exp_rdy;
    logic mv;
    logic [CW-1:0] mc;
    pulse_reset();
    seq = 4'b1011;
    ch_valid = '1;
    for (int c = 0; c < 16; c++) begin
      ch_data = {NCH{seq[3 - c/4]}};
      #1;
      rdy = ch_ready;
      @(posedge clk); #1;
      mv = match_valid;
      mc = match_ch;
      exp_rdy = NCH'(1) << (c % 4);
      n_checks++;
      if (rdy !== exp_rdy) begin
        n_fail++; $display("FAIL b2b_ready cyc %0d: got %b want %b", c, rdy, exp_rdy);
      end
      n_checks++;
      if (mv !== (c >= 12)) begin
        n_fail++; $display("FAIL b2b_mv cyc %0d: got %b want %b", c, mv, (c >= 12));
      end
      if (c >= 12) begin
        n_checks++;
        if (mc !== CW'(c % 4)) begin
          n_fail++; $display("FAIL b2b_mc cyc %0d: got %0d want %0d", c, mc, c % 4);
        end
      end
    end
    ch_valid = '0;
    ch_data = '0;
  endtask

  task automatic test_cfg_discard();
    logic [6:0] seq;
    logic [6:0] exp;
    logic [NCH-1:0] crdy;
    logic rdy, mv;
    logic [CW-1:0] mc;
    // 1,0,1 | cfg | 1,0,1,1 : only the complete post-config window matches
    seq = 7'b1011011;
    exp = 7'b0000001;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        do_cfg(4'b1011, 1'b1, crdy, mv);
      end
      send_bit(2, seq[6-i], rdy, mv, mc);
      n_checks++;
      if (mv !== exp[6-i]) begin
        n_fail++; $display("FAIL disc_mv bit %0d: got %b want %b", i, mv, exp[6-i]);
      end
    end
    n_checks++;
    if (mc !== 2'd2) begin
      n_fail++; $display("FAIL disc_mc: got %0d want 2", mc);
    end
  endtask

  task automatic test_reset_midstream();
    logic [6:0] seq;
    logic [6:0] exp;
    logic rdy, mv;
    logic [CW-1:0] mc;
    seq = 7'b1011011;
    exp = 7'b0000001;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        ch_valid = 4'b0010;
        rst = 1'b0;
        #1;
        n_checks++;
        if (ch_ready !== 4'b0000) begin
          n_fail++; $display("FAIL mrst_ready: got %b want 0000", ch_ready);
        end
        n_checks++;
        if (match_valid !== 1'b0) begin
          n_fail++; $display("FAIL mrst_mv: got %b want 0", match_valid);
        end
        n_checks++;
        if (match_ch !== 2'd0) begin
          n_fail++; $display("FAIL mrst_mc: got %0d want 0", match_ch);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        ch_valid = '0;
      end
      send_bit(1, seq[6-i], rdy, mv, mc);
      n_checks++;
      if (mv !== exp[6-i]) begin
        n_fail++; $display("FAIL mrst_bit %0d: got %b want %b", i, mv, exp[6-i]);
      end
    end
    n_checks++;
    if (mc !== 2'd1) begin
      n_fail++; $display("FAIL mrst_hit_mc: got %0d want 1", mc);
    end
  endtask

  task automatic test_idle();
    ch_valid = '0;
    #1;
    n_checks++;
    if (ch_ready !== 4'b0000) begin
      n_fail++; $display("FAIL idle_ready: got %b want 0000", ch_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (match_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_mv: got %b want 0", match_valid);
    end
    n_checks++;
    if (match_ch !== 2'd1) begin
      n_fail++; $display("FAIL idle_mc_hold: got %0d want 1", match_ch);
    end
  endtask

`ifdef MATCH_CNT_EN
  task automatic test_counters();
    logic [NCH-1:0] crdy;
    logic rdy, mv;
    logic [CW-1:0] mc;
    logic [3:0] pre;
    logic [2:0] rep;
    do_cfg(4'b1011, 1'b1, crdy, mv);
    cnt_sel = 2'd3;
    #1;
    n_checks++;
    if (cnt_rdata !== 8'd0) begin
      n_fail++; $display("FAIL cnt_clear: got %0d want 0", cnt_rdata);
    end
    pre = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      send_bit(3, pre[3-i], rdy, mv, mc);
    end
    n_checks++;
    if (cnt_rdata !== 8'd1) begin
      n_fail++; $display("FAIL cnt_first: got %0d want 1", cnt_rdata);
    end
    rep = 3'b011;
    for (int m = 0; m < 299; m++) begin
      for (int i = 0; i < 3; i++) begin
        send_bit(3, rep[2-i], rdy, mv, mc);
      end
    end
    n_checks++;
    if (cnt_rdata !== 8'd255) begin
      n_fail++; $display("FAIL cnt_sat: got %0d want 255", cnt_rdata);
    end
    cnt_sel = 2'd0;
    #1;
    n_checks++;
    if (cnt_rdata !== 8'd0) begin
      n_fail++; $display("FAIL cnt_ch0: got %0d want 0", cnt_rdata);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b0;
    cfg_we = 1'b0;
    cfg_pattern = 4'b0000;
    cfg_overlap = 1'b0;
    ch_valid = '0;
    ch_data = '0;
`ifdef MATCH_CNT_EN
    cnt_sel = '0;
`endif
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_back_to_back();
    test_cfg_discard();
    test_reset_midstream();
    test_idle();
`ifdef MATCH_CNT_EN
    test_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
